// File: rtl/pc_sequencer_pkg.sv
// Shared core definitions for the PC sequencer: address width, FSM states
// and the next-PC select encoding used by decode.
package pc_sequencer_pkg;

    localparam int unsigned AW = 4;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        STEP = 2'd2
    } seq_state_t;

    typedef enum logic [1:0] {
        SEL_HOLD   = 2'd0,
        SEL_RET    = 2'd1,
        SEL_TARGET = 2'd2,
        SEL_SEQ    = 2'd3
    } npc_sel_t;

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address LIFO; a push when full silently replaces the oldest entry.
module ras_stack #(
    parameter int unsigned AW    = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top_c,
    output logic          full_c,
    output logic          empty_c,
    output logic          ovf_c,
    output logic          unf_c,
    output logic [DW-1:0] depth
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [AW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;

    assign full_c  = (depth == DW'(DEPTH));
    assign empty_c = (depth == '0);
    assign top_c   = mem[wr_ptr - PW'(1)];
    assign ovf_c   = push && !pop && full_c;
    assign unf_c   = pop && empty_c;

    // Pointer and occupancy; pop takes precedence if both are requested.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            depth  <= '0;
        end else if (pop) begin
            if (!empty_c) begin
                wr_ptr <= wr_ptr - PW'(1);
                depth  <= depth - DW'(1);
            end
        end else if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
            if (!full_c) begin
                depth <= depth + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && push && !pop) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: priority redirect mux, return-address stack and
// RUN/HALT/STEP debug state machine.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned AW    = pc_sequencer_pkg::AW,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [AW-1:0]            pc_in,
    input  logic                     branch_taken,
    input  logic                     jump,
    input  logic [AW-1:0]            target,
    input  logic                     call,
    input  logic                     ret,
    input  logic                     stall,
    input  logic                     halt_req,
    input  logic                     resume,
    input  logic                     step,
    output logic [AW-1:0]            next_pc,
    output logic                     redirect,
    output logic                     wrap,
    output logic                     halted,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     ovf_err,
    output logic                     unf_err
);

    localparam int unsigned DW = $clog2(DEPTH) + 1;

    seq_state_t    state;
    npc_sel_t      sel;
    logic          active;
    logic          push;
    logic          pop;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] ras_top;
    logic          ras_full;
    logic          ras_empty;
    logic          ras_ovf;
    logic          ras_unf;

    assign active = (state != HALT);
    assign pc_inc = pc_in + AW'(1);
    assign pop    = reset_n && active && !stall && ret;
    assign push   = reset_n && active && !stall && !ret && call;

    ras_stack #(
        .AW    (AW),
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_ras (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top_c     (ras_top),
        .full_c    (ras_full),
        .empty_c   (ras_empty),
        .ovf_c     (ras_ovf),
        .unf_c     (ras_unf),
        .depth     (depth)
    );

    // Priority select; a ret on an empty stack falls through to sequential.
    always_comb begin
        sel = SEL_SEQ;
        if (!active || stall) begin
            sel = SEL_HOLD;
        end else if (ret) begin
            sel = ras_empty ? SEL_SEQ : SEL_RET;
        end else if (call || jump || branch_taken) begin
            sel = SEL_TARGET;
        end
    end

    always_comb begin
        next_pc  = '0;
        redirect = 1'b0;
        wrap     = 1'b0;
        if (reset_n) begin
            unique case (sel)
                SEL_HOLD:   next_pc = pc_in;
                SEL_RET:    next_pc = ras_top;
                SEL_TARGET: next_pc = target;
                default:    next_pc = pc_inc;
            endcase
            redirect = (sel == SEL_RET) || (sel == SEL_TARGET);
            wrap     = (sel == SEL_SEQ) && (pc_in == {AW{1'b1}});
        end
    end

    // Debug FSM with registered halted decode and sticky stack error flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= RUN;
            halted  <= 1'b0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (halt_req) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end
                end
                HALT: begin
                    if (resume) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end else if (step) begin
                        state  <= STEP;
                        halted <= 1'b0;
                    end
                end
                STEP: begin
                    state  <= HALT;
                    halted <= 1'b1;
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
            if (ras_ovf) ovf_err <= 1'b1;
            if (ras_unf) unf_err <= 1'b1;
        end
    end

    logic unused_full;
    assign unused_full = ras_full;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer with immediate-assertion checks.
module tb_pc_sequencer;

    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] pc_in;
    logic          branch_taken;
    logic          jump;
    logic [AW-1:0] target;
    logic          call;
    logic          ret;
    logic          stall;
    logic          halt_req;
    logic          resume;
    logic          step;
    logic [AW-1:0] next_pc;
    logic          redirect;
    logic          wrap;
    logic          halted;
    logic [DW-1:0] depth;
    logic          ovf_err;
    logic          unf_err;

    int vectors = 0;
    int errors  = 0;

    pc_sequencer #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pc_in        (pc_in),
        .branch_taken (branch_taken),
        .jump         (jump),
        .target       (target),
        .call         (call),
        .ret          (ret),
        .stall        (stall),
        .halt_req     (halt_req),
        .resume       (resume),
        .step         (step),
        .next_pc      (next_pc),
        .redirect     (redirect),
        .wrap         (wrap),
        .halted       (halted),
        .depth        (depth),
        .ovf_err      (ovf_err),
        .unf_err      (unf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        branch_taken = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0;
        stall = 1'b0; halt_req = 1'b0; resume = 1'b0; step = 1'b0;
        target = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [AW-1:0] exp_pc;
        clr();
        reset_n = 1'b0;
        pc_in   = 4'd15;
        jump    = 1'b1;
        target  = 4'd3;
        #2;
        chk("rst_next_pc", 32'(next_pc), 32'd0);
        chk("rst_redirect", 32'(redirect), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        cyc();
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_ovf", 32'(ovf_err), 32'd0);
        chk("rst_unf", 32'(unf_err), 32'd0);
        clr();
        reset_n = 1'b1;

        // Free run: 0,1,...,15,0
        exp_pc = 4'd0;
        for (int i = 0; i < 16; i++) begin
            pc_in = exp_pc;
            #1;
            chk("seq_next_pc", 32'(next_pc), 32'(AW'(exp_pc + 4'd1)));
            chk("seq_wrap", 32'(wrap), (exp_pc == 4'd15) ? 32'd1 : 32'd0);
            exp_pc = next_pc;
            cyc();
        end
        chk("seq_final_pc", 32'(exp_pc), 32'd0);

        // Call then return
        pc_in = 4'd3; call = 1'b1; target = 4'd9;
        #1;
        chk("call_next_pc", 32'(next_pc), 32'd9);
        chk("call_redirect", 32'(redirect), 32'd1);
        cyc();
        chk("call_depth", 32'(depth), 32'd1);
        clr();
        pc_in = 4'd11; ret = 1'b1;
        #1;
        chk("ret_next_pc", 32'(next_pc), 32'd4);
        chk("ret_redirect", 32'(redirect), 32'd1);
        cyc();
        chk("ret_depth", 32'(depth), 32'd0);
        chk("ret_unf", 32'(unf_err), 32'd0);
        clr();

        // Five nested calls overflow, five returns underflow
        for (int i = 0; i < 5; i++) begin
            pc_in = AW'(i); call = 1'b1; target = 4'd8;
            cyc();
        end
        clr();
        chk("ovf_depth", 32'(depth), 32'd4);
        chk("ovf_flag", 32'(ovf_err), 32'd1);
        pc_in = 4'd8; ret = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("pop_next_pc", 32'(next_pc), 32'(5 - i));
            chk("pop_redirect", 32'(redirect), 32'd1);
            cyc();
        end
        chk("pop_unf_before", 32'(unf_err), 32'd0);
        chk("unf_next_pc", 32'(next_pc), 32'd9);
        chk("unf_redirect", 32'(redirect), 32'd0);
        cyc();
        chk("unf_flag", 32'(unf_err), 32'd1);
        chk("unf_depth", 32'(depth), 32'd0);
        clr();

        // Stall outranks call/jump; call+ret pops only
        pc_in = 4'd1; call = 1'b1; target = 4'd2;
        cyc();
        clr();
        pc_in = 4'd6; stall = 1'b1; call = 1'b1; jump = 1'b1; target = 4'd12;
        #1;
        chk("stall_next_pc", 32'(next_pc), 32'd6);
        chk("stall_redirect", 32'(redirect), 32'd0);
        cyc();
        chk("stall_depth", 32'(depth), 32'd1);
        stall = 1'b0; jump = 1'b0; ret = 1'b1;
        #1;
        chk("callret_next_pc", 32'(next_pc), 32'd2);
        cyc();
        chk("callret_depth", 32'(depth), 32'd0);
        clr();

        // Halt, ignore controls while halted, single step, resume
        pc_in = 4'd5; halt_req = 1'b1;
        #1;
        chk("halt_req_next_pc", 32'(next_pc), 32'd6);
        chk("halt_req_halted", 32'(halted), 32'd0);
        cyc();
        clr();
        chk("halted_set", 32'(halted), 32'd1);
        pc_in = 4'd6; jump = 1'b1; call = 1'b1; target = 4'd12;
        #1;
        chk("halt_next_pc", 32'(next_pc), 32'd6);
        chk("halt_redirect", 32'(redirect), 32'd0);
        cyc();
        chk("halt_depth", 32'(depth), 32'd0);
        clr();
        step = 1'b1;
        #1;
        chk("step_req_next_pc", 32'(next_pc), 32'd6);
        cyc();
        step = 1'b0;
        chk("step_halted", 32'(halted), 32'd0);
        chk("step_next_pc", 32'(next_pc), 32'd7);
        cyc();
        pc_in = 4'd7;
        chk("step_back_halted", 32'(halted), 32'd1);
        #1;
        chk("step_back_next_pc", 32'(next_pc), 32'd7);
        resume = 1'b1; step = 1'b1;
        cyc();
        clr();
        chk("resume_halted", 32'(halted), 32'd0);
        chk("resume_next_pc", 32'(next_pc), 32'd8);

        // Reset while in STEP with two entries stacked
        pc_in = 4'd0; call = 1'b1; target = 4'd1;
        cyc();
        pc_in = 4'd1; target = 4'd2;
        cyc();
        clr();
        halt_req = 1'b1;
        cyc();
        clr();
        step = 1'b1;
        cyc();
        clr();
        chk("pre_rst_depth", 32'(depth), 32'd2);
        chk("pre_rst_halted", 32'(halted), 32'd0);
        reset_n = 1'b0; pc_in = 4'd3;
        #1;
        chk("mid_rst_next_pc", 32'(next_pc), 32'd0);
        cyc();
        reset_n = 1'b1;
        chk("post_rst_depth", 32'(depth), 32'd0);
        chk("post_rst_halted", 32'(halted), 32'd0);
        chk("post_rst_ovf", 32'(ovf_err), 32'd0);
        chk("post_rst_unf", 32'(unf_err), 32'd0);
        #1;
        chk("post_rst_next_pc", 32'(next_pc), 32'd4);
        cyc();
        chk("post_rst_run", 32'(halted), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the mini RISC-V core. Each cycle it computes the value loaded into the program counter register: sequential increment, branch/jump redirect, or call/return through a 4-entry return-address stack. A RUN/HALT/STEP state machine gives halt, resume and single-step debug control. It sits between the decode/branch logic and the PC register, and drives that register's `next_pc` input.

## Interface
Parameters:
- `AW`, 4: PC/address width in bits (16 instruction locations).
- `DEPTH`, 4: return-address stack entries; must be a power of two.

Ports:
- `clk` input 1: clock, all state updates on rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `pc_in` input AW: current PC register value.
- `branch_taken` input 1: conditional branch resolved taken this cycle.
- `jump` input 1: unconditional jump this cycle.
- `target` input AW: destination for branch, jump or call.
- `call` input 1: jump to `target`, push `pc_in+1`.
- `ret` input 1: pop return address into PC.
- `stall` input 1: hold PC this cycle.
- `halt_req` input 1: enter HALT.
- `resume` input 1: leave HALT to RUN.
- `step` input 1: in HALT, execute exactly one instruction.
- `next_pc` output AW: value to load into the PC register.
- `redirect` output 1: `next_pc` is non-sequential this cycle.
- `wrap` output 1: sequential increment from all-ones to 0 this cycle.
- `halted` output 1: state is HALT.
- `depth` output log2(DEPTH)+1: current stack occupancy, 0..DEPTH.
- `ovf_err` output 1: sticky, a call was made with the stack full.
- `unf_err` output 1: sticky, a ret was made with the stack empty.

## Operation
- FSM states:
  - RUN (reset state).
  - HALT.
  - STEP: a one-instruction window.
- FSM transitions:
  - RUN→HALT on `halt_req`.
  - HALT→RUN on `resume`.
  - HALT→STEP on `step` when `resume` is low; `resume` wins if both are high.
  - STEP→HALT unconditionally after one cycle.
- "Active" means state is RUN or STEP. While active, `next_pc` is selected by strict priority:
  1. `stall`: `pc_in`.
  2. `ret`: top of stack.
  3. `call`: `target`.
  4. `jump` or `branch_taken`: `target`.
  5. Otherwise: `pc_in+1`, modulo 2^AW.
- HALT: `next_pc = pc_in`; all control inputs except `resume`/`step` are ignored and the stack is unchanged.
- In RUN, `halt_req` does not affect the current cycle's `next_pc`. The instruction in that cycle completes; the halt takes effect from the next cycle.
- In STEP, `stall` holds the PC but the step is still consumed and the FSM returns to HALT.
- Stack push and pop happen only when active and the higher-priority `stall` is low.
- Push on `call`:
  - Stores `pc_in+1` (wrapping).
  - If full: the oldest entry is discarded, the stack is treated as circular, `depth` stays at DEPTH, and `ovf_err` is set.
- Pop on `ret`:
  - If non-empty: `next_pc` = top of stack and `depth` decrements.
  - If empty: `next_pc = pc_in+1`, `depth` stays 0, `unf_err` is set, and `redirect` is low.
- `call` and `ret` asserted together: `ret` wins, so only the pop happens.
- `redirect` = 1 when active, not stalled, and the selection is ret (non-empty), call, jump or branch.
- `wrap` = 1 when the sequential path is selected and `pc_in` is all-ones.
- `ovf_err` and `unf_err` are cleared only by reset.

## Timing
- `next_pc`, `redirect` and `wrap` are combinational from the inputs, the registered FSM state and the stack. Zero latency: the PC register loads the selected value on the same edge.
- FSM state, stack contents, `depth` and the error flags update on the rising `clk` edge.
- `halted` is a registered decode of state.
- `reset_n` low at an edge:
  - Results: state=RUN, `depth`=0, `ovf_err`=0, `unf_err`=0, `halted`=0; stack contents don't-care.
  - While `reset_n` is low, `next_pc`=0, `redirect`=0 and `wrap`=0, overriding everything.
  - A reset mid-step or while halted returns to RUN.

## Structure
- Shared core package holds:
  - `AW`.
  - FSM state enum `seq_state_t`: RUN, HALT, STEP.
  - The next-PC select encoding, shared with decode.
- One sub-module is natural: `ras_stack`, a circular LIFO with push/pop, full/empty, `depth` and overflow/underflow pulses. The sequencer owns the FSM, the priority mux and the sticky flags.

## Test plan
- Reset, then 16 free-running cycles with `pc_in` fed back from `next_pc` → PC sequence 0,1,…,15,0; `wrap`=1 only when `pc_in`=15.
- `pc_in`=3, `call`, `target`=9 → `next_pc`=9, `redirect`=1, `depth`=1. Later `pc_in`=11, `ret` → `next_pc`=4, `depth`=0.
- Five nested calls from `pc_in`=0,1,2,3,4 → `ovf_err`=1, `depth`=4. Five returns → 5,4,3,2, then fifth ret gives `next_pc`=`pc_in+1` with `unf_err`=1.
- `stall`, `call` and `jump` together at `pc_in`=6 → `next_pc`=6, `depth` unchanged, `redirect`=0. The same cycle with `call`+`ret` and `depth`=1 → pop only.
- `halt_req` at `pc_in`=5 → `next_pc`=6 that cycle, then `halted`=1 and `next_pc`=`pc_in` regardless of `jump`. `step` → exactly one advance, back to HALT. `resume`+`step` → RUN.
- Drive `reset_n`=0 while in STEP with `depth`=2 → next cycle state RUN, `depth`=0, `next_pc`=0 during reset.
